// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// instruction classes and the per-class datapath select helper.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  // TRAP is split three ways so the fault code lives in the state register.
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB,
    S_TRAP_ILL, S_TRAP_FETCH, S_TRAP_DATA
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
  } cls_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_FETCH   = 2'b10;
  localparam logic [1:0] FC_DATA    = 2'b11;

  typedef struct packed {
    logic       src_a;
    logic       src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_sel;
  } dp_sel_t;

  // ALU/immediate selects held constant through EXEC, MEM and WB of a class.
  function automatic dp_sel_t dp_sel_for(cls_t cls);
    dp_sel_t s;
    s = '0;
    case (cls)
      CLS_R:      s.alu_op = ALU_R;
      CLS_I:      begin s.src_b = 1'b1; s.alu_op = ALU_I; end
      CLS_LOAD:   s.src_b = 1'b1;
      CLS_JALR:   s.src_b = 1'b1;
      CLS_STORE:  begin s.src_b = 1'b1; s.imm_sel = IMM_S; end
      CLS_BRANCH: begin s.alu_op = ALU_BR; s.imm_sel = IMM_B; end
      CLS_JAL:    s.imm_sel = IMM_J;
      CLS_LUI:    s.imm_sel = IMM_U;
      CLS_AUIPC:  begin s.src_a = 1'b1; s.src_b = 1'b1; s.imm_sel = IMM_U; end
      default:    s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rv_opcode_decode.sv
// Combinational RV32I classifier: instruction class plus an illegal-encoding flag.
module rv_opcode_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output cls_t       cls,
  output logic       illegal
);

  always_comb begin
    cls     = CLS_R;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        cls     = CLS_R;
        illegal = !((funct7 == 7'h00) ||
                    (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OP_I: begin
        cls = CLS_I;
        // Only the shift-immediate forms carry funct7 bits that must be checked.
        if (funct3 == 3'b001)
          illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OP_LOAD:   begin cls = CLS_LOAD;   illegal = (funct3 != 3'b010); end
      OP_STORE:  begin cls = CLS_STORE;  illegal = (funct3 != 3'b010); end
      OP_BRANCH: begin
        cls     = CLS_BRANCH;
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   begin cls = CLS_JALR;   illegal = (funct3 != 3'b000); end
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a
// shared memory port, with illegal-encoding trap and memory watchdog.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_sel,
  output logic       retire,
  output logic       fault,
  output logic [1:0] fault_code,
  output state_t     dbg_state
);

  localparam int            CW       = (CNT_W > 0) ? CNT_W : 1;
  localparam bit            WD_EN    = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(WD_EN ? TIMEOUT - 1 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cls_t          cls;
  logic          illegal;
  dp_sel_t       sel;
  logic          wd_expire;

  rv_opcode_decode u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .cls     (cls),
    .illegal (illegal)
  );

  assign sel       = dp_sel_for(cls);
  assign dbg_state = state_q;

  // Handshake: mem_req is held (never retracted) until a cycle with mem_ready
  // high completes the transfer, or the watchdog expires; mem_ready wins a tie.
  assign wd_expire = WD_EN && !mem_ready && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    imm_sel      = IMM_I;
    retire       = 1'b0;
    fault        = 1'b0;
    fault_code   = FC_NONE;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wd_expire) begin
          state_d = S_TRAP_FETCH;
        end
      end
      S_DECODE: state_d = illegal ? S_TRAP_ILL : S_EXEC;
      S_EXEC: begin
        {alu_src_a, alu_src_b, alu_op, imm_sel} = sel;
        if (cls == CLS_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (cls == CLS_LOAD || cls == CLS_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        {alu_src_a, alu_src_b, alu_op, imm_sel} = sel;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == CLS_STORE);
        if (mem_ready) begin
          if (cls == CLS_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wd_expire) begin
          state_d = S_TRAP_DATA;
        end
      end
      S_WB: begin
        {alu_src_a, alu_src_b, alu_op, imm_sel} = sel;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        case (cls)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL:  begin wb_sel = WB_PC4; pc_src = PC_IMM; end
          CLS_JALR: begin wb_sel = WB_PC4; pc_src = PC_ALU; end
          CLS_LUI:  wb_sel = WB_IMM;
          default:  wb_sel = WB_ALU;
        endcase
      end
      S_TRAP_ILL:   begin fault = 1'b1; fault_code = FC_ILLEGAL; end
      S_TRAP_FETCH: begin fault = 1'b1; fault_code = FC_FETCH;   end
      S_TRAP_DATA:  begin fault = 1'b1; fault_code = FC_DATA;    end
      default:      state_d = S_IDLE;
    endcase

    // Watchdog restarts on every state change so each request gets a fresh budget.
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (WD_EN && mem_req && !mem_ready)
      cnt_d = cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed self-checking bench for rv_multicycle_ctrl (watchdog TIMEOUT=4).
module tb_rv_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write;
  logic       alu_src_a, alu_src_b, retire, fault;
  logic [1:0] pc_src, wb_sel, alu_op, fault_code;
  logic [2:0] imm_sel;
  state_t     dbg_state;
  logic [20:0] all_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  rv_multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .retire       (retire),
    .fault        (fault),
    .fault_code   (fault_code),
    .dbg_state    (dbg_state)
  );

  assign all_out = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                    reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, imm_sel,
                    retire, fault, fault_code};

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7;
  endtask

  // Called at a falling edge: apply inputs, let combinational outputs settle.
  task automatic cyc(input logic rdy, input logic bt);
    mem_ready = rdy; branch_taken = bt; #1;
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  // Leaves the bench at a falling edge with the DUT in FETCH.
  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    @(negedge clk); #1;
    check("rst_outs", all_out, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Walks FETCH, DECODE, EXEC with no wait states; returns in the cycle after EXEC.
  task automatic to_post_exec(input logic bt);
    cyc(1'b1, 1'b0); adv();
    cyc(1'b0, 1'b0); adv();
    cyc(1'b0, bt);   adv();
  endtask

  typedef struct packed {
    logic [6:0] op; logic [2:0] f3;
    logic [1:0] wb; logic [1:0] pcs; logic [2:0] imm; logic chk_imm;
    logic a; logic b; logic chk_ab;
  } wb_vec_t;

  typedef struct packed {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic ill;
  } ill_vec_t;

  wb_vec_t wb_tab [5] = '{
    '{7'h67, 3'd0, 2'b10, 2'b10, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1},  // JALR
    '{7'h6F, 3'd0, 2'b10, 2'b01, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0},  // JAL
    '{7'h37, 3'd0, 2'b11, 2'b00, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0},  // LUI
    '{7'h17, 3'd0, 2'b00, 2'b00, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1},  // AUIPC
    '{7'h13, 3'd0, 2'b00, 2'b00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1}   // ADDI
  };

  ill_vec_t ill_tab [11] = '{
    '{7'h33, 3'd1, 7'h20, 1'b1},  // R f7=0x20 with SLL
    '{7'h33, 3'd0, 7'h20, 1'b0},  // SUB
    '{7'h33, 3'd0, 7'h01, 1'b1},  // R bad funct7
    '{7'h13, 3'd1, 7'h20, 1'b1},  // SLLI bad funct7
    '{7'h13, 3'd5, 7'h20, 1'b0},  // SRAI
    '{7'h03, 3'd0, 7'h00, 1'b1},  // LB unsupported
    '{7'h23, 3'd1, 7'h00, 1'b1},  // SH unsupported
    '{7'h63, 3'd2, 7'h00, 1'b1},  // branch f3=010
    '{7'h63, 3'd6, 7'h00, 1'b0},  // BLTU
    '{7'h7F, 3'd0, 7'h00, 1'b1},  // unknown opcode
    '{7'h73, 3'd0, 7'h00, 1'b1}   // SYSTEM not in set
  };

  // ---------------- directed tests ----------------
  initial begin
    logic [3:0] st_exp;

    do_reset();

    // R-type add, zero wait states.
    set_instr(OP_R, 3'b000, 7'h00);
    exp_q = '{S_FETCH, S_DECODE, S_EXEC, S_WB};
    for (int c = 0; c < 4; c++) begin
      cyc(1'b1, 1'b0);
      check("radd_state", dbg_state, exp_q.pop_front());
      check("radd_retire", retire, (c == 3));
      if (c == 2) check("radd_alu_op", alu_op, 2'b10);
      if (c == 3) begin
        check("radd_reg_write", reg_write, 1'b1);
        check("radd_wb_sel", wb_sel, 2'b00);
        check("radd_pc_src", pc_src, 2'b00);
      end
      adv();
    end

    // Load with three MEM wait states; WB lands in cycle 8.
    set_instr(OP_LOAD, 3'b010, 7'h00);
    exp_q = '{S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MEM, S_MEM, S_MEM, S_WB};
    for (int c = 0; c < 8; c++) begin
      cyc((c == 0) || (c >= 6), 1'b0);
      check("lw_state", dbg_state, exp_q.pop_front());
      if (c >= 3 && c <= 6) begin
        check("lw_mem_req", mem_req, 1'b1);
        check("lw_addr_sel", mem_addr_sel, 1'b1);
        check("lw_mem_we", mem_we, 1'b0);
      end
      if (c == 7) begin
        check("lw_wb_sel", wb_sel, 2'b01);
        check("lw_reg_write", reg_write, 1'b1);
        check("lw_retire", retire, 1'b1);
      end
      adv();
    end

    // BEQ taken then not taken; retire in cycle 3.
    for (int t = 1; t >= 0; t--) begin
      set_instr(OP_BRANCH, 3'b000, 7'h00);
      cyc(1'b1, 1'b0); adv();
      cyc(1'b0, 1'b0); adv();
      cyc(1'b0, t[0]);
      check("beq_state", dbg_state, S_EXEC);
      check("beq_pc_write", pc_write, 1'b1);
      check("beq_pc_src", pc_src, (t == 1) ? 2'b01 : 2'b00);
      check("beq_retire", retire, 1'b1);
      check("beq_alu_op", alu_op, 2'b01);
      check("beq_imm_sel", imm_sel, 3'd2);
      adv();
      cyc(1'b0, 1'b0);
      check("beq_next_state", dbg_state, S_FETCH);
    end

    // Write-back variants.
    for (int i = 0; i < 5; i++) begin
      set_instr(wb_tab[i].op, wb_tab[i].f3, 7'h00);
      to_post_exec(1'b0);
      cyc(1'b0, 1'b0);
      check($sformatf("wb%0d_state", i), dbg_state, S_WB);
      check($sformatf("wb%0d_wb_sel", i), wb_sel, wb_tab[i].wb);
      check($sformatf("wb%0d_pc_src", i), pc_src, wb_tab[i].pcs);
      check($sformatf("wb%0d_retire", i), {reg_write, pc_write, retire}, 3'b111);
      if (wb_tab[i].chk_imm) check($sformatf("wb%0d_imm", i), imm_sel, wb_tab[i].imm);
      if (wb_tab[i].chk_ab)  check($sformatf("wb%0d_ab", i), {alu_src_a, alu_src_b},
                                   {wb_tab[i].a, wb_tab[i].b});
      adv();
    end

    // Store, zero wait: retire in MEM (cycle 4).
    set_instr(OP_STORE, 3'b010, 7'h00);
    to_post_exec(1'b0);
    cyc(1'b1, 1'b0);
    check("sw_state", dbg_state, S_MEM);
    check("sw_bus", {mem_req, mem_we, mem_addr_sel}, 3'b111);
    check("sw_retire", {pc_write, retire, reg_write}, 3'b110);
    check("sw_pc_src", pc_src, 2'b00);
    adv();
    cyc(1'b0, 1'b0);
    check("sw_next_state", dbg_state, S_FETCH);

    // JALR with funct3=001 traps; fault is sticky until reset.
    set_instr(OP_JALR, 3'b001, 7'h00);
    cyc(1'b1, 1'b0); adv();
    cyc(1'b0, 1'b0); adv();
    cyc(1'b0, 1'b0);
    check("jalr_ill_fault", {fault, fault_code}, 3'b101);
    check("jalr_ill_mem_req", mem_req, 1'b0);
    for (int c = 0; c < 5; c++) begin
      adv();
      cyc(c[0], 1'b1);
      check("jalr_ill_sticky", {fault, fault_code}, 3'b101);
    end
    do_reset();

    // Illegal-encoding table.
    for (int i = 0; i < 11; i++) begin
      if (i > 0) do_reset();
      set_instr(ill_tab[i].op, ill_tab[i].f3, ill_tab[i].f7);
      cyc(1'b1, 1'b0); adv();
      cyc(1'b0, 1'b0); adv();
      cyc(1'b0, 1'b0);
      st_exp = ill_tab[i].ill ? S_TRAP_ILL : S_EXEC;
      check($sformatf("ill%0d_state", i), dbg_state, st_exp);
      check($sformatf("ill%0d_fault", i), {fault, fault_code},
            ill_tab[i].ill ? 3'b101 : 3'b000);
    end

    // Fetch watchdog: four request cycles without mem_ready then TRAP code 10.
    do_reset();
    set_instr(OP_R, 3'b000, 7'h00);
    for (int c = 0; c < TO; c++) begin
      cyc(1'b0, 1'b0);
      check("wdf_state", dbg_state, S_FETCH);
      check("wdf_mem_req", mem_req, 1'b1);
      adv();
    end
    cyc(1'b0, 1'b0);
    check("wdf_trap", dbg_state, S_TRAP_FETCH);
    check("wdf_fault", {fault, fault_code}, 3'b110);
    check("wdf_mem_req_off", mem_req, 1'b0);

    // mem_ready in exactly the 4th request cycle beats the timeout.
    do_reset();
    for (int c = 0; c < TO - 1; c++) begin
      cyc(1'b0, 1'b0); adv();
    end
    cyc(1'b1, 1'b0);
    check("wdf_edge_ir_write", ir_write, 1'b1);
    adv();
    cyc(1'b0, 1'b0);
    check("wdf_edge_state", dbg_state, S_DECODE);
    check("wdf_edge_fault", fault, 1'b0);

    // Data watchdog in MEM: TRAP code 11.
    do_reset();
    set_instr(OP_LOAD, 3'b010, 7'h00);
    to_post_exec(1'b0);
    for (int c = 0; c < TO; c++) begin
      cyc(1'b0, 1'b0);
      check("wdd_state", dbg_state, S_MEM);
      adv();
    end
    cyc(1'b0, 1'b0);
    check("wdd_trap", dbg_state, S_TRAP_DATA);
    check("wdd_fault", {fault, fault_code}, 3'b111);

    // Asynchronous reset in the middle of a stalled store.
    do_reset();
    set_instr(OP_STORE, 3'b010, 7'h00);
    to_post_exec(1'b0);
    cyc(1'b0, 1'b0);
    check("arst_pre_we", mem_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", all_out, 0);
    check("arst_state", dbg_state, S_IDLE);
    @(negedge clk); #1;
    check("arst_hold_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    #1;
    check("arst_rel_outs", all_out, 0);
    adv();
    cyc(1'b0, 1'b0);
    check("arst_fetch_state", dbg_state, S_FETCH);
    check("arst_fetch_bus", {mem_req, mem_we, mem_addr_sel}, 3'b100);
    adv();
    cyc(1'b0, 1'b0);
    check("arst_no_we", mem_we, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
